// File: rtl/cacheline_adapter_pkg.sv
// Shared constants, FSM encoding and address helper for the cacheline adapter.
package cacheline_adapter_pkg;

  localparam int WORD_W    = 64;
  localparam int BURST_LEN = 4;
  localparam int LINE_W    = WORD_W * BURST_LEN;
  localparam int ADDR_W    = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_DATA,
    WR_DATA,
    DONE
  } state_t;

  // Clears the byte-offset bits so the address points at the start of a line.
  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(LINE_W / 8 - 1);
  endfunction

endpackage

// File: rtl/cacheline_adapter_if.sv
// Bus bundle between the cache arbiter (umem_*) and the burst memory (bmem_*).
interface cacheline_adapter_if #(
  parameter int WORD_W    = cacheline_adapter_pkg::WORD_W,
  parameter int BURST_LEN = cacheline_adapter_pkg::BURST_LEN
);

  localparam int LINE_W = WORD_W * BURST_LEN;

  // Handshake: umem_read/umem_write are levels held until the one-cycle
  // umem_resp pulse. A burst command (bmem_read) or write beat (bmem_write)
  // transfers on a cycle where it and bmem_ready are both high. Read beats
  // have no backpressure; they are qualified by bmem_rvalid and the
  // bmem_raddr line tag.
  logic [31:0]       umem_addr;
  logic              umem_read;
  logic              umem_write;
  logic [LINE_W-1:0] umem_wdata;
  logic [LINE_W-1:0] umem_rdata;
  logic              umem_resp;
  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [WORD_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [31:0]       bmem_raddr;
  logic [WORD_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  modport slave (
    input  umem_addr, umem_read, umem_write, umem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output umem_rdata, umem_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata
  );

  modport master (
    output umem_addr, umem_read, umem_write, umem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  umem_rdata, umem_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata
  );

endinterface

// File: rtl/cacheline_adapter.sv
// Converts one 256-bit line request into a four-beat 64-bit memory burst and
// reassembles tagged read beats back into a line.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
#(
  parameter int WORD_W    = cacheline_adapter_pkg::WORD_W,
  parameter int BURST_LEN = cacheline_adapter_pkg::BURST_LEN
) (
  input  logic                clk,
  input  logic                rst,
  cacheline_adapter_if.slave  bus,
  output state_t              o_state
);

  localparam int LINE_W = WORD_W * BURST_LEN;
  localparam int CNT_W  = $clog2(BURST_LEN);

  state_t             r_state;
  logic [CNT_W-1:0]   r_beat;
  logic [ADDR_W-1:0]  r_addr;
  logic [LINE_W-1:0]  r_wline;
  logic [LINE_W-1:0]  r_line;
  logic [LINE_W-1:0]  r_rdata;
  logic               r_resp;
  logic               r_bmem_read;
  logic               r_bmem_write;
  logic [WORD_W-1:0]  r_bmem_wdata;

  logic [LINE_W-1:0]  w_line;
  logic [CNT_W-1:0]   w_beat_inc;
  logic               w_last;
  logic               w_hit;

  assign w_beat_inc = r_beat + CNT_W'(1);
  assign w_last     = (r_beat == CNT_W'(BURST_LEN - 1));
  // Beats tagged for any other line belong to someone else and are dropped.
  assign w_hit      = bus.bmem_rvalid && (bus.bmem_raddr == r_addr);

  always_comb begin
    w_line = r_line;
    w_line[WORD_W*r_beat +: WORD_W] = bus.bmem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_addr       <= '0;
      r_wline      <= '0;
      r_line       <= '0;
      r_rdata      <= '0;
      r_resp       <= 1'b0;
      r_bmem_read  <= 1'b0;
      r_bmem_write <= 1'b0;
      r_bmem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_beat <= '0;
          if (bus.umem_write) begin
            r_addr       <= align_addr(bus.umem_addr);
            r_wline      <= bus.umem_wdata;
            r_bmem_write <= 1'b1;
            r_bmem_wdata <= bus.umem_wdata[WORD_W-1:0];
            r_state      <= WR_DATA;
          end else if (bus.umem_read) begin
            r_addr      <= align_addr(bus.umem_addr);
            r_bmem_read <= 1'b1;
            r_state     <= RD_CMD;
          end
        end
        RD_CMD: begin
          if (bus.bmem_ready) begin
            r_bmem_read <= 1'b0;
            r_state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (w_hit) begin
            r_line <= w_line;
            r_beat <= w_beat_inc;
            if (w_last) begin
              r_rdata <= w_line;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        WR_DATA: begin
          if (bus.bmem_ready) begin
            r_beat <= w_beat_inc;
            if (w_last) begin
              r_bmem_write <= 1'b0;
              r_resp       <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_bmem_wdata <= r_wline[WORD_W*w_beat_inc +: WORD_W];
            end
          end
        end
        DONE: begin
          r_resp  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.umem_rdata = r_rdata;
  assign bus.umem_resp  = r_resp;
  assign bus.bmem_addr  = r_addr;
  assign bus.bmem_read  = r_bmem_read;
  assign bus.bmem_write = r_bmem_write;
  assign bus.bmem_wdata = r_bmem_wdata;
  assign o_state        = r_state;

endmodule
